// File: rtl/i2c_master.sv
// Single-byte I2C bus master: START, 7-bit address + R/W, one data byte, STOP.
// Open-drain SDA/SCL; SCL input is not observed (no clock stretching).
module i2c_master #(
  parameter int CLK_DIV = 250
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  input  logic [6:0] i_cmd_addr,
  input  logic       i_cmd_rw,
  input  logic [7:0] i_cmd_wdata,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ack_err,
  output logic [7:0] o_rdata,
  inout  wire        io_sda,
  inout  wire        io_scl
);

  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_WDATA,
    S_WACK,
    S_RDATA,
    S_RNACK,
    S_STOP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_qcnt;
  logic [1:0]      r_quarter;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic [7:0]      r_wdata;
  logic            r_rw;
  logic            r_sda_smp;
  logic            r_busy;
  logic            r_done;
  logic            r_ack_err;
  logic [7:0]      r_rdata;

  logic            w_qlast;
  logic            w_bit_end;
  logic            w_sample;
  logic            w_accept;
  logic            w_sda_low;
  logic            w_scl_low;
  logic            w_done_set;
  logic            w_ackerr_set;

  assign w_qlast   = (r_qcnt == CW'(CLK_DIV - 1));
  assign w_bit_end = w_qlast && (r_quarter == 2'd3);
  assign w_sample  = (r_qcnt == '0) && (r_quarter == 2'd3) && (r_state != S_IDLE);

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_sda_low    = 1'b0;
    w_scl_low    = 1'b0;
    w_done_set   = 1'b0;
    w_ackerr_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid && !r_busy) begin
          w_accept    = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_sda_low = r_quarter[1];
        if (w_bit_end) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        w_scl_low = !r_quarter[1];
        w_sda_low = !r_shift[7];
        if (w_bit_end && (r_bitcnt == 3'd0)) w_state_nxt = S_ADDR_ACK;
      end
      S_ADDR_ACK: begin
        w_scl_low = !r_quarter[1];
        if (w_bit_end) begin
          if (r_sda_smp) begin
            w_ackerr_set = 1'b1;
            w_state_nxt  = S_STOP;
          end else begin
            w_state_nxt = r_rw ? S_RDATA : S_WDATA;
          end
        end
      end
      S_WDATA: begin
        w_scl_low = !r_quarter[1];
        w_sda_low = !r_shift[7];
        if (w_bit_end && (r_bitcnt == 3'd0)) w_state_nxt = S_WACK;
      end
      S_WACK: begin
        w_scl_low = !r_quarter[1];
        if (w_bit_end) begin
          w_ackerr_set = r_sda_smp;
          w_state_nxt  = S_STOP;
        end
      end
      S_RDATA: begin
        w_scl_low = !r_quarter[1];
        if (w_bit_end && (r_bitcnt == 3'd0)) w_state_nxt = S_RNACK;
      end
      S_RNACK: begin
        w_scl_low = !r_quarter[1];
        if (w_bit_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        // SDA rises at the start of q3 while SCL is high: the STOP condition.
        w_scl_low = !r_quarter[1];
        w_sda_low = (r_quarter != 2'd3);
        if (w_bit_end) begin
          w_done_set  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_qcnt    <= '0;
      r_quarter <= 2'd0;
      r_bitcnt  <= 3'd7;
      r_shift   <= 8'h00;
      r_wdata   <= 8'h00;
      r_rw      <= 1'b0;
      r_sda_smp <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_rdata   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_set;
      if (w_accept) begin
        r_busy    <= 1'b1;
        r_ack_err <= 1'b0;
        r_rw      <= i_cmd_rw;
        r_wdata   <= i_cmd_wdata;
        r_shift   <= {i_cmd_addr, i_cmd_rw};
        r_bitcnt  <= 3'd7;
        r_qcnt    <= '0;
        r_quarter <= 2'd0;
      end else if (r_state != S_IDLE) begin
        if (w_qlast) begin
          r_qcnt    <= '0;
          r_quarter <= r_quarter + 2'd1;
        end else begin
          r_qcnt <= r_qcnt + CW'(1);
        end
        if (w_sample) r_sda_smp <= io_sda;
        // One shift register serves address out, write data out and read data in.
        if (w_bit_end) begin
          case (r_state)
            S_ADDR, S_WDATA, S_RDATA: begin
              r_shift  <= {r_shift[6:0], r_sda_smp};
              r_bitcnt <= r_bitcnt - 3'd1;
            end
            S_ADDR_ACK: r_shift <= r_wdata;
            default: ;
          endcase
        end
        if (w_ackerr_set) r_ack_err <= 1'b1;
        if (w_done_set) begin
          r_busy <= 1'b0;
          if (r_rw && !r_ack_err) r_rdata <= r_shift;
        end
      end
    end
  end

  assign io_sda    = w_sda_low ? 1'b0 : 1'bz;
  assign io_scl    = w_scl_low ? 1'b0 : 1'bz;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_ack_err = r_ack_err;
  assign o_rdata   = r_rdata;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with a behavioural slave at 7'h2A and a
// bus monitor checking SCL phase lengths and START/STOP-only SDA edges.
module tb_i2c_master;
  localparam int CD = 2;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic [6:0] cmd_addr;
  logic       cmd_rw;
  logic [7:0] cmd_wdata;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [7:0] rdata;
  wire        sda;
  wire        scl;

  pullup (sda);
  pullup (scl);

  i2c_master #(.CLK_DIV(CD)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cmd_valid (cmd_valid),
    .i_cmd_addr  (cmd_addr),
    .i_cmd_rw    (cmd_rw),
    .i_cmd_wdata (cmd_wdata),
    .o_busy      (busy),
    .o_done      (done),
    .o_ack_err   (ack_err),
    .o_rdata     (rdata),
    .io_sda      (sda),
    .io_scl      (scl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0    = 0;
  int lat   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural slave at 7'h2A; returns s_tx on reads.
  logic       p_sda = 1'b1, p_scl = 1'b1;
  logic       s_act = 1'b0, s_drv = 1'b0;
  logic [3:0] s_bitn = 4'd0;
  logic [1:0] s_ph = 2'd0;
  logic [7:0] s_shift = 8'h00, s_addr = 8'h00, s_rx = 8'h00;
  logic [7:0] s_tx = 8'hCC;

  assign sda = s_drv ? 1'b0 : 1'bz;

  always @(posedge clk) begin
    p_sda <= sda;
    p_scl <= scl;
    if (p_scl && scl && p_sda && !sda) begin
      s_act <= 1'b1; s_bitn <= 4'd0; s_ph <= 2'd0; s_drv <= 1'b0;
    end else if (p_scl && scl && !p_sda && sda) begin
      s_act <= 1'b0; s_drv <= 1'b0;
    end else if (s_act && !p_scl && scl) begin
      if (s_bitn < 4'd8 && s_ph != 2'd2) s_shift <= {s_shift[6:0], sda};
      s_bitn <= s_bitn + 4'd1;
    end else if (s_act && p_scl && !scl) begin
      if (s_bitn == 4'd8) begin
        case (s_ph)
          2'd0: begin s_addr <= s_shift; s_drv <= (s_shift[7:1] == 7'h2A); end
          2'd1: begin s_rx <= s_shift; s_drv <= 1'b1; end
          default: s_drv <= 1'b0;
        endcase
      end else if (s_bitn == 4'd9) begin
        s_bitn <= 4'd0;
        if (s_ph == 2'd0 && s_addr[7:1] == 7'h2A) begin
          s_ph  <= s_addr[0] ? 2'd2 : 2'd1;
          s_drv <= s_addr[0] ? !s_tx[7] : 1'b0;
        end else begin
          s_act <= 1'b0; s_drv <= 1'b0;
        end
      end else if (s_ph == 2'd2) begin
        s_drv <= !s_tx[3'd7 - s_bitn[2:0]];
      end
    end
  end

  // Bus monitor: samples on the falling clk edge.
  logic        m_psda = 1'b1, m_pscl = 1'b1;
  logic        phase_en = 1'b1;
  int          run = 0;
  int          n_rise = 0, n_start = 0, n_stop = 0;
  logic [31:0] bitlog = 32'h0;

  always @(negedge clk) begin
    if (scl !== m_pscl) begin
      if (phase_en) begin
        if (!m_pscl) chk("scl_low_len", 32'(run), 32'(2 * CD));
        else         chk("scl_high_len", 32'(run == 2 * CD || run >= 4 * CD), 32'd1);
      end
      if (scl) begin
        n_rise = n_rise + 1;
        bitlog = {bitlog[30:0], sda};
      end
      run = 1;
    end else begin
      run = run + 1;
      if (scl && (sda !== m_psda)) begin
        if (!sda) begin
          n_start = n_start + 1;
          n_rise  = 0;
          bitlog  = 32'h0;
        end else begin
          n_stop = n_stop + 1;
        end
      end
    end
    m_pscl = scl;
    m_psda = sda;
  end

  task automatic start_cmd(input logic [6:0] a, input logic rw, input logic [7:0] wd, input bit hold);
    @(negedge clk);
    cmd_addr  = a;
    cmd_rw    = rw;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 c0 = cyc;
    if (!hold) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done(output int l);
    l = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        l = cyc - c0;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = 7'h00; cmd_rw = 1'b0; cmd_wdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ackerr", 32'(ack_err), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'h00);
    chk("rst_sda", 32'(sda), 32'd1);
    chk("rst_scl", 32'(scl), 32'd1);
    rst = 1'b0;

    // Write 8'hA5 to 7'h2A, with an ignored cmd_valid pulse while busy
    start_cmd(7'h2A, 1'b0, 8'hA5, 1'b0);
    chk("wr_busy", 32'(busy), 32'd1);
    repeat (20) @(negedge clk);
    cmd_addr = 7'h11; cmd_rw = 1'b1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(lat);
    chk("wr_latency", 32'(lat >= 80 * CD - 1 && lat <= 80 * CD + 1), 32'd1);
    chk("wr_busy_at_done", 32'(busy), 32'd0);
    chk("wr_ackerr", 32'(ack_err), 32'd0);
    chk("wr_slave_addr", 32'(s_addr), 32'h54);
    chk("wr_slave_data", 32'(s_rx), 32'hA5);
    chk("wr_bus_bits", bitlog, 32'({8'h54, 1'b0, 8'hA5, 1'b0, 1'b0}));
    chk("wr_rises", 32'(n_rise), 32'd19);
    @(negedge clk);
    chk("wr_done_pulse", 32'(done), 32'd0);
    repeat (10) @(negedge clk);
    chk("wr_no_queue", 32'(busy), 32'd0);

    // Read from 7'h2A; slave returns 8'hCC
    start_cmd(7'h2A, 1'b1, 8'h00, 1'b0);
    wait_done(lat);
    chk("rd_latency", 32'(lat >= 80 * CD - 1 && lat <= 80 * CD + 1), 32'd1);
    chk("rd_ackerr", 32'(ack_err), 32'd0);
    chk("rd_rdata", 32'(rdata), 32'hCC);
    chk("rd_bus_bits", bitlog, 32'({8'h55, 1'b0, 8'hCC, 1'b1, 1'b0}));
    chk("rd_rises", 32'(n_rise), 32'd19);

    // Handshake: cmd_valid held, back-to-back writes
    start_cmd(7'h2A, 1'b0, 8'h3C, 1'b1);
    wait_done(lat);
    chk("hs1_latency", 32'(lat >= 80 * CD - 1 && lat <= 80 * CD + 1), 32'd1);
    chk("hs1_data", 32'(s_rx), 32'h3C);
    cmd_wdata = 8'hC3;
    @(negedge clk);
    c0 = cyc;
    chk("hs2_accept", 32'(busy), 32'd1);
    repeat (30) @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(lat);
    chk("hs2_latency", 32'(lat >= 80 * CD - 1 && lat <= 80 * CD + 1), 32'd1);
    chk("hs2_data", 32'(s_rx), 32'hC3);
    repeat (5) @(negedge clk);
    chk("hs_no_third", 32'(busy), 32'd0);

    // Address NACK at 7'h11
    start_cmd(7'h11, 1'b0, 8'h5A, 1'b0);
    wait_done(lat);
    chk("nack_latency", 32'(lat >= 44 * CD - 1 && lat <= 44 * CD + 1), 32'd1);
    chk("nack_ackerr", 32'(ack_err), 32'd1);
    chk("nack_rdata_held", 32'(rdata), 32'hCC);
    chk("nack_bus_bits", bitlog, 32'({8'h22, 1'b1, 1'b0}));
    chk("nack_rises", 32'(n_rise), 32'd10);

    // Reset after 3 address bits, while SCL is low
    start_cmd(7'h2A, 1'b0, 8'hA5, 1'b0);
    for (int i = 0; i < 500 && n_rise != 3; i++) @(negedge clk);
    chk("rst_reach_bit3", 32'(n_rise), 32'd3);
    for (int i = 0; i < 50 && scl !== 1'b0; i++) @(negedge clk);
    chk("rst_scl_low", 32'(scl), 32'd0);
    phase_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_sda", 32'(sda), 32'd1);
    chk("mid_rst_scl", 32'(scl), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ackerr", 32'(ack_err), 32'd0);
    chk("mid_rst_rdata", 32'(rdata), 32'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Normal write after reset
    phase_en = 1'b1;
    start_cmd(7'h2A, 1'b0, 8'h96, 1'b0);
    wait_done(lat);
    chk("post_rst_latency", 32'(lat >= 80 * CD - 1 && lat <= 80 * CD + 1), 32'd1);
    chk("post_rst_ackerr", 32'(ack_err), 32'd0);
    chk("post_rst_data", 32'(s_rx), 32'h96);
    chk("post_rst_rdata", 32'(rdata), 32'h00);

    repeat (5) @(negedge clk);
    chk("start_count", 32'(n_start), 32'd7);
    chk("stop_count", 32'(n_stop), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
# i2c_master

Single-byte I2C bus master that generates START, the 7-bit address plus R/W bit, one data byte (write or read) and STOP on open-drain SDA/SCL lines. It sits directly upstream of the team's address-0x2A I2C slave and is the only bus driver besides slave-side ACK and read data. A host issues one transaction per command through a valid/busy handshake and gets a done pulse, an ACK-error flag and the read byte.

## Interface
- CLK_DIV, 250: clk cycles per SCL quarter-period. One bit period is 4·CLK_DIV cycles; 250 gives 100 kHz at 100 MHz. Legal range is ≥2.
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  transaction request; accepted only when busy=0
- cmd_addr  input  7  target slave address
- cmd_rw  input  1  0 = write byte to slave, 1 = read byte from slave
- cmd_wdata  input  8  byte to write; ignored when cmd_rw=1
- busy  output  1  high from the cycle after acceptance until done
- done  output  1  one-cycle pulse when STOP completes
- ack_err  output  1  valid with done; 1 = address or write-data NACK received
- rdata  output  8  read byte; updated with done on successful reads, otherwise held
- sda  inout  1  open drain: driven 0 or 'bz, never driven 1
- scl  inout  1  open drain: driven 0 or 'bz; clock stretching is not supported and the scl input is ignored

## Operation
- Reset values: busy=0, done=0, ack_err=0, rdata=8'h00, sda and scl released (z), state IDLE.
- Acceptance: in IDLE, with cmd_valid=1 and busy=0, latch addr, rw and wdata, set busy=1 on the next cycle, and clear ack_err. cmd_valid while busy is ignored and never queued.
- Quarter counter: counts 0..CLK_DIV-1 and advances quarter q0→q1→q2→q3.
  - q0/q1: scl held low; sda is updated on the first cycle of q0.
  - q2/q3: scl released.
  - Sampled sda is registered on the first cycle of q3.
- States:
  - IDLE: lines released.
  - START: q0–q1 sda and scl released; q2–q3 sda low with scl released. Then go to ADDR with scl low.
  - ADDR: 8 bits, MSB first: addr[6:0], then rw. Bit counter runs 7→0.
  - ADDR_ACK: sda released and sampled in q3. Sample 1 → ack_err=1, go to STOP. Sample 0 → go to WDATA if rw=0, RDATA if rw=1.
  - WDATA: 8 bits of wdata, MSB first.
  - WACK: sda released and sampled. 1 → ack_err=1. Go to STOP in both cases.
  - RDATA: sda released; shift the sample into a shift register MSB first over 8 bits.
  - RNACK: master releases sda (NACK) for one bit, then goes to STOP.
  - STOP:
    - q0–q1: scl low, sda low.
    - q2: scl released, sda low.
    - q3: sda released.
    - On the last cycle of q3: done=1; rdata is loaded if rw=1 and ack_err=0; busy clears in the same cycle as done; go to IDLE.
- The next command may be accepted in the cycle after done.
- Reset mid-transaction: on the next rising edge both lines are released and state returns to IDLE with reset values. No STOP is generated, no done pulse is issued, and the bus may show a spurious STOP edge.

## Timing
- Bit period: 4·CLK_DIV clk cycles. SCL is low for 2·CLK_DIV cycles, then high for 2·CLK_DIV cycles.
- Transaction lengths, measured from the acceptance edge to the done pulse:
  - Write or read: (1 START + 9 + 9 + 1 STOP) bit periods = 80·CLK_DIV cycles, ±1 cycle for registering.
  - Address NACK: (1 + 9 + 1) bit periods = 44·CLK_DIV cycles.
- SDA changes only while SCL is low, except the START falling edge and the STOP rising edge, which occur while SCL is high.
- done and busy falling are coincident. ack_err and rdata are stable from done until the next acceptance.

## Test plan
- Write, CLK_DIV=2, with a bench slave at 7'h2A: addr=7'h2A, rw=0, wdata=8'hA5. Bus must show START, bits 0101010_0 ACK, 10100101 ACK, STOP. Slave must capture 8'hA5. done must arrive 160±1 cycles after acceptance with ack_err=0.
- Read, same slave returning 8'hCC: rw=1. Master must release SDA for all 8 data bits and the NACK bit. Response: done, rdata=8'hCC, ack_err=0.
- Address NACK: addr=7'h11, no slave at that address. Response: ack_err=1 and STOP right after the 9th bit. done arrives 88±1 cycles after acceptance. rdata keeps its previous value and no data bits are clocked.
- Handshake: hold cmd_valid=1 across a whole transaction. Response: exactly one transaction per done, with the second accepted the cycle after done. A cmd_valid pulse while busy must produce no effect.
- Reset mid-ADDR (after 3 bits): response on the next cycle is sda=z, scl=z, busy=0, done=0, ack_err=0, rdata=0. A following write transaction must complete normally.
- Bus protocol checker throughout all scenarios: no SDA change while SCL is high except at START/STOP, sda and scl are never driven to 1, and every SCL high and low phase lasts exactly 2·CLK_DIV cycles.
